// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receives 8N1 asynchronous serial frames (start, 8 data bits LSB first,
//   1 stop) from the rx pin. Each byte arrives as a parallel word with a
//   one-cycle valid strobe. This is the receive counterpart of the transmitter.
//   It uses the same baud parameters and the same line format.
//
// Ports
//   clock        in   1  system clock
//   reset        in   1  asynchronous reset, active-high
//   rx           in   1  serial line, asynchronous to clock, idle high
//   data_out     out  8  last correctly framed byte, held until the next good frame
//   rx_valid     out  1  one-cycle pulse: data_out updated this cycle
//   frame_error  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//   rx_busy      out  1  high from start-bit detection until return to IDLE
//
// Handshake: none. rx_valid is a single-cycle strobe with no ready/backpressure.
//   The consumer must capture data_out in the cycle rx_valid is high. A later
//   good frame overwrites data_out.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int BAUDRATE   = 115200,
   parameter int CLOCK_FREQ = 27000000,
   parameter int BAUD_TICKS = CLOCK_FREQ / BAUDRATE,
   parameter int HALF_TICKS = BAUD_TICKS / 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       frame_error,
   output logic       rx_busy
);

   localparam logic [15:0] BAUD_LIMIT = 16'(BAUD_TICKS - 1);
   localparam logic [15:0] HALF_LIMIT = 16'(HALF_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t      state;
   logic        rx_meta;
   logic        rx_s;
   logic [15:0] counter;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        half_tick;
   logic        baud_tick;

   assign half_tick = (counter == HALF_LIMIT);
   assign baud_tick = (counter == BAUD_LIMIT);

   // Two-flop synchronizer. It resets to the idle (high) line level, so
   // releasing reset never looks like a start edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM. The counter restarts on every state change. In DATA it also
   // restarts after each sample. The half-bit wait in START moves every later
   // sample to the centre of its bit. rx_valid and frame_error default low, so
   // each one lasts exactly one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         counter     <= 16'd0;
         bit_idx     <= 3'd0;
         shift       <= 8'h00;
         data_out    <= 8'h00;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         rx_busy     <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            S_IDLE: begin
               counter <= 16'd0;
               if (!rx_s) begin
                  state   <= S_START;
                  rx_busy <= 1'b1;
               end
            end
            S_START: begin
               if (half_tick) begin
                  counter <= 16'd0;
                  if (!rx_s) begin
                     state   <= S_DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     // Line went back high before mid-start: a glitch, not a frame.
                     state   <= S_IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  counter <= 16'd0;
                  shift   <= {rx_s, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= S_STOP;
                  end
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            S_STOP: begin
               if (baud_tick) begin
                  counter <= 16'd0;
                  if (rx_s) begin
                     // Return at mid-stop-bit so an immediately following start
                     // bit is still seen.
                     data_out <= shift;
                     rx_valid <= 1'b1;
                     state    <= S_IDLE;
                     rx_busy  <= 1'b0;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= S_BREAK;
                  end
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            S_BREAK: begin
               // A held-low line must go high before another start is accepted.
               counter <= 16'd0;
               if (rx_s) begin
                  state   <= S_IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               counter <= 16'd0;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
